// File: rtl/bch_decode_sched_pkg.sv
// Shared types and helpers for the BCH decode sequencer.
package bch_decode_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STALL = 2'd2
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    localparam int DEF_DATA_BEATS = 8;
    localparam int CNT_W          = clog2(DEF_DATA_BEATS);

endpackage

// File: rtl/bch_decode_sched_fifo.sv
// Show-ahead tag FIFO: head is visible on rd_data with no latency; read and write may share a cycle.
module bch_tag_fifo
    import bch_decode_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_rd, do_wr;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rd_data  = mem_q[rd_ptr_q[AW-1:0]];
        do_rd    = rd_en && !empty;
        // A full FIFO still takes a write when the same cycle frees a slot.
        do_wr    = wr_en && (!full || do_rd);
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        if (do_wr && !reset) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/bch_decode_sched.sv
// BCH decode sequencer: syndrome beat loading, key-solver handoff and per-codeword tag tracking.
// Define BCH_DECODE_SCHED_STATS_EN to add saturating word/stall counters.
module bch_decode_sched
    import bch_decode_sched_pkg::*;
#(
    parameter int DATA_BEATS = 8,
    parameter int TAG_W      = 4,
    parameter int DEPTH      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             in_ready,
    input  logic             syn_ready,
    input  logic             syn_done,
    output logic             syn_start,
    output logic             syn_ce,
    input  logic             key_ready,
    output logic             key_start,
    input  logic             err_first,
    input  logic             err_valid,
    input  logic             err_last,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_last,
    output logic             busy,
    output logic             protocol_err
`ifdef BCH_DECODE_SCHED_STATS_EN
    ,
    output logic [31:0]      stat_words,
    output logic [31:0]      stat_stalls
`endif
);
    localparam int BEAT_W = clog2(DATA_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DATA_BEATS - 1);

    state_e            state_q, state_d;
    state_e            saved_q, saved_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              perr_q, perr_d;
    logic              accept, chien, pop;
    logic              fifo_full, fifo_empty;
    logic [TAG_W-1:0]  fifo_head;

    bch_tag_fifo #(.DEPTH(DEPTH), .W(TAG_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (syn_start),
        .wr_data (in_tag),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        syn_ce       = !syn_done || key_ready;
        key_start    = syn_done && key_ready;
        in_ready     = syn_ce && ((state_q == LOAD) ||
                                  (state_q == IDLE && syn_ready && !fifo_full));
        accept       = in_valid && in_ready;
        syn_start    = accept && (state_q != LOAD);
        chien        = err_first || err_valid;
        out_valid    = chien && !fifo_empty;
        out_last     = err_last && out_valid;
        pop          = out_last;
        out_tag      = fifo_empty ? '0 : fifo_head;
        busy         = !fifo_empty || (beat_cnt_q != '0);
        protocol_err = perr_q;
        perr_d       = perr_q || (chien && fifo_empty);

        state_d    = state_q;
        saved_d    = saved_q;
        beat_cnt_d = beat_cnt_q;
        if (state_q == STALL) begin
            if (key_ready) state_d = saved_q;
        end else if (syn_done && !key_ready) begin
            // No beat is accepted this cycle (syn_ce is low), so the current state is the resume point.
            state_d = STALL;
            saved_d = state_q;
        end else if (accept) begin
            if (state_q == IDLE) begin
                state_d    = LOAD;
                beat_cnt_d = BEAT_W'(1);
            end else if (beat_cnt_q == LAST_BEAT) begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            saved_q    <= IDLE;
            beat_cnt_q <= '0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            saved_q    <= saved_d;
            beat_cnt_q <= beat_cnt_d;
            perr_q     <= perr_d;
        end
    end

`ifdef BCH_DECODE_SCHED_STATS_EN
    logic [31:0] stat_words_q, stat_words_d;
    logic [31:0] stat_stalls_q, stat_stalls_d;

    always_comb begin
        stat_words_d  = stat_words_q;
        stat_stalls_d = stat_stalls_q;
        if (pop && stat_words_q != '1) stat_words_d = stat_words_q + 32'd1;
        if (state_q == STALL && stat_stalls_q != '1) stat_stalls_d = stat_stalls_q + 32'd1;
        stat_words  = stat_words_q;
        stat_stalls = stat_stalls_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_words_q  <= '0;
            stat_stalls_q <= '0;
        end else begin
            stat_words_q  <= stat_words_d;
            stat_stalls_q <= stat_stalls_d;
        end
    end
`endif

endmodule

// File: tb/tb_bch_decode_sched.sv
// Self-checking bench for bch_decode_sched: directed scenarios plus randomized traffic vs. a queue model.
module tb_bch_decode_sched;
    localparam int DATA_BEATS = 8;
    localparam int TAG_W      = 4;
    localparam int DEPTH      = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             in_ready;
    logic             syn_ready = 1'b0;
    logic             syn_done = 1'b0;
    logic             syn_start;
    logic             syn_ce;
    logic             key_ready = 1'b0;
    logic             key_start;
    logic             err_first = 1'b0;
    logic             err_valid = 1'b0;
    logic             err_last = 1'b0;
    logic             out_valid;
    logic [TAG_W-1:0] out_tag;
    logic             out_last;
    logic             busy;
    logic             protocol_err;
`ifdef BCH_DECODE_SCHED_STATS_EN
    logic [31:0]      stat_words;
    logic [31:0]      stat_stalls;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bch_decode_sched #(.DATA_BEATS(DATA_BEATS), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_tag       (in_tag),
        .in_ready     (in_ready),
        .syn_ready    (syn_ready),
        .syn_done     (syn_done),
        .syn_start    (syn_start),
        .syn_ce       (syn_ce),
        .key_ready    (key_ready),
        .key_start    (key_start),
        .err_first    (err_first),
        .err_valid    (err_valid),
        .err_last     (err_last),
        .out_valid    (out_valid),
        .out_tag      (out_tag),
        .out_last     (out_last),
        .busy         (busy),
        .protocol_err (protocol_err)
`ifdef BCH_DECODE_SCHED_STATS_EN
        ,
        .stat_words   (stat_words),
        .stat_stalls  (stat_stalls)
`endif
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: a word is "open" while fewer than DATA_BEATS beats have arrived;
    // tags of words whose first beat was taken wait in a queue until their Chien last beat.
    logic [TAG_W-1:0] tag_q[$];
    int               beats_seen = 0;
    bit               stalled = 0;
    bit               perr_m = 0;
    int               words_m = 0;
    int               stalls_m = 0;

    initial begin
        bit e_ce, e_ks, e_rdy, e_acc, e_start, e_chien, e_ov, e_last, e_busy, e_full;
        logic [TAG_W-1:0] e_tag, push_tag;
        bit was_reset;
        forever begin
            @(negedge clk);
            was_reset = reset;
            if (!reset) begin
                e_full  = (tag_q.size() == DEPTH);
                e_ce    = !syn_done || key_ready;
                e_ks    = syn_done && key_ready;
                e_rdy   = !stalled && e_ce && (beats_seen != 0 || (syn_ready && !e_full));
                e_acc   = in_valid && e_rdy;
                e_start = e_acc && beats_seen == 0;
                e_chien = err_first || err_valid;
                e_ov    = e_chien && tag_q.size() != 0;
                e_last  = e_ov && err_last;
                e_tag   = (tag_q.size() != 0) ? tag_q[0] : '0;
                e_busy  = tag_q.size() != 0 || beats_seen != 0;
                push_tag = in_tag;
                chk("syn_ce", syn_ce, e_ce);
                chk("key_start", key_start, e_ks);
                chk("in_ready", in_ready, e_rdy);
                chk("syn_start", syn_start, e_start);
                chk("out_valid", out_valid, e_ov);
                chk("out_last", out_last, e_last);
                chk("out_tag", out_tag, e_tag);
                chk("busy", busy, e_busy);
                chk("protocol_err", protocol_err, perr_m);
`ifdef BCH_DECODE_SCHED_STATS_EN
                chk("stat_words", stat_words, words_m);
                chk("stat_stalls", stat_stalls, stalls_m);
`endif
            end
            @(posedge clk);
            if (was_reset) begin
                tag_q.delete();
                beats_seen = 0;
                stalled = 0;
                perr_m = 0;
                words_m = 0;
                stalls_m = 0;
            end else begin
                if (stalled) stalls_m++;
                if (e_chien && tag_q.size() == 0) perr_m = 1;
                if (e_last) begin
                    void'(tag_q.pop_front());
                    words_m++;
                end
                if (e_start) tag_q.push_back(push_tag);
                if (e_acc) beats_seen = (beats_seen + 1) % DATA_BEATS;
                stalled = stalled ? !key_ready : (syn_done && !key_ready);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        in_valid = 0; in_tag = '0; syn_ready = 0; syn_done = 0; key_ready = 0;
        err_first = 0; err_valid = 0; err_last = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        clear_inputs();
        tick(); tick();
        reset = 0;
    endtask

    task automatic chien_one(input logic [TAG_W-1:0] exp_tag, input string name);
        err_first = 1; err_last = 1;
        settle();
        chk({name, "_tag"}, out_tag, exp_tag);
        chk({name, "_last"}, out_last, 1);
        tick();
        err_first = 0; err_last = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: single word, tag 3
        do_reset();
        settle();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_perr", protocol_err, 0);
        chk("rst_syn_ce", syn_ce, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_tag", out_tag, 0);
        key_ready = 1; syn_ready = 1;
        for (int b = 0; b < DATA_BEATS; b++) begin
            in_valid = 1;
            in_tag = (b == 0) ? 4'h3 : 4'hf;
            settle();
            chk("t1_in_ready", in_ready, 1);
            chk("t1_syn_start", syn_start, (b == 0));
            tick();
        end
        in_valid = 0;
        syn_done = 1;
        settle();
        chk("t1_key_start", key_start, 1);
        tick();
        syn_done = 0;
        err_first = 1;
        settle();
        chk("t1_first_tag", out_tag, 3);
        chk("t1_first_valid", out_valid, 1);
        tick();
        err_first = 0; err_valid = 1;
        settle();
        chk("t1_mid_tag", out_tag, 3);
        chk("t1_mid_last", out_last, 0);
        tick();
        err_last = 1;
        settle();
        chk("t1_last_tag", out_tag, 3);
        chk("t1_last", out_last, 1);
        tick();
        err_valid = 0; err_last = 0;
        settle();
        chk("t1_busy_after", busy, 0);

        // Test 2: tags 1..4 back to back fill the FIFO; fifth word waits for a pop
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < DATA_BEATS; b++) begin
                in_valid = 1; in_tag = TAG_W'(w + 1);
                settle();
                chk("t2_in_ready", in_ready, 1);
                chk("t2_syn_start", syn_start, (b == 0));
                tick();
            end
        end
        in_tag = 4'h5;
        settle();
        chk("t2_blocked", in_ready, 0);
        tick();
        err_first = 1;
        settle();
        chk("t2_blocked_first", in_ready, 0);
        chk("t2_head1", out_tag, 1);
        tick();
        err_first = 0; err_valid = 1; err_last = 1;
        settle();
        chk("t2_blocked_pop", in_ready, 0);
        chk("t2_pop1", out_last, 1);
        tick();
        err_valid = 0; err_last = 0;
        settle();
        chk("t2_unblocked", in_ready, 1);
        chk("t2_start5", syn_start, 1);
        tick();
        for (int b = 1; b < DATA_BEATS; b++) tick();
        in_valid = 0;
        chien_one(4'h2, "t2_w2");
        chien_one(4'h3, "t2_w3");
        chien_one(4'h4, "t2_w4");
        chien_one(4'h5, "t2_w5");
        settle();
        chk("t2_busy_after", busy, 0);

        // Test 3: key solver busy for 5 cycles while syndromes are ready
        in_valid = 1; in_tag = 4'h6; syn_done = 1; key_ready = 0;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("t3_syn_ce", syn_ce, 0);
            chk("t3_in_ready", in_ready, 0);
            chk("t3_key_start_lo", key_start, 0);
            tick();
        end
        in_valid = 0; key_ready = 1;
        settle();
        chk("t3_key_start_hi", key_start, 1);
        chk("t3_syn_ce_hi", syn_ce, 1);
        tick();
        syn_done = 0;
        settle();
        chk("t3_key_start_once", key_start, 0);
        tick();

        // Test 4: Chien beat with an empty FIFO
        err_first = 1;
        settle();
        chk("t4_out_valid", out_valid, 0);
        tick();
        err_first = 0;
        settle();
        chk("t4_perr_set", protocol_err, 1);
        tick(); tick();
        settle();
        chk("t4_perr_sticky", protocol_err, 1);

        // Test 5: reset on beat 3 of a word
        do_reset();
        key_ready = 1; syn_ready = 1;
        for (int b = 0; b < 3; b++) begin
            in_valid = 1; in_tag = 4'h7;
            tick();
        end
        reset = 1;
        tick();
        reset = 0; in_valid = 0;
        settle();
        chk("t5_busy", busy, 0);
        chk("t5_perr", protocol_err, 0);
        err_first = 1;
        settle();
        chk("t5_stale_valid", out_valid, 0);
        tick();
        err_first = 0;
        in_valid = 1; in_tag = 4'h9;
        settle();
        chk("t5_perr_stale", protocol_err, 1);
        chk("t5_new_start", syn_start, 1);
        tick();
        for (int b = 1; b < DATA_BEATS; b++) tick();
        in_valid = 0;
        chien_one(4'h9, "t5_w9");

`ifdef BCH_DECODE_SCHED_STATS_EN
        // Test 6: 3 words and 2 stall cycles
        do_reset();
        key_ready = 1; syn_ready = 1;
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < DATA_BEATS; b++) begin
                in_valid = 1; in_tag = TAG_W'(w + 10);
                tick();
            end
        end
        in_valid = 0;
        syn_done = 1; key_ready = 0;
        tick(); tick();
        key_ready = 1;
        tick();
        syn_done = 0;
        chien_one(4'ha, "t6_wa");
        chien_one(4'hb, "t6_wb");
        chien_one(4'hc, "t6_wc");
        settle();
        chk("t6_stat_words", stat_words, 3);
        chk("t6_stat_stalls", stat_stalls, 2);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            reset     = ($urandom_range(0, 399) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_tag    = TAG_W'($urandom);
            syn_ready = ($urandom_range(0, 9) < 8);
            syn_done  = ($urandom_range(0, 9) < 2);
            key_ready = ($urandom_range(0, 9) < 7);
            err_first = ($urandom_range(0, 9) < 1);
            err_valid = ($urandom_range(0, 9) < 3);
            err_last  = ($urandom_range(0, 9) < 3);
            tick();
        end
        reset = 0;
        clear_inputs();
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
